lcd_hex_display: RTL
====================

Name: lcd_hex_display

Overview:
- Parametrised HD44780 (16x2) character-LCD driver that shows a status letter and a DATA_W-bit word as hex, e.g. a CRC result and its pass/fail flag.
- Generalises the fixed-string LCD driver with:
  - configurable data width and display line;
  - real enable-pulse and command timing instead of a free-running divided enable;
  - a valid/ready update handshake, so the display can be refreshed at runtime.
- Sits between the CRC/serial datapath and the LCD pins.

Parameters:
- DATA_W, 32, width of displayed word; multiple of 4, range 4..56.
- LINE, 0, display row; 0 = DDRAM base 0x00, 1 = DDRAM base 0x40.
- POR_CYC, 750000, power-on wait before the first command (15 ms at 50 MHz).
- SETUP_CYC, 2, cycles rs/dat are stable before lcd_en rises.
- EN_CYC, 12, lcd_en high time in cycles.
- GAP_CYC, 2000, cycles after lcd_en falls before the next transfer (40 us).
- CLR_CYC, 82000, gap used after the Clear command 0x01 (1.64 ms).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- upd_valid, in, 1, new value offered.
- upd_ready, out, 1, block accepts the update this cycle.
- upd_data, in, DATA_W, word to display.
- upd_ok, in, 1, status: 1 shows 'C', 0 shows 'E'.
- busy, out, 1, initialising or writing.
- lcd_rs, out, 1, register select (0 = command, 1 = data).
- lcd_rw, out, 1, constant 0.
- lcd_en, out, 1, enable strobe.
- lcd_dat, out, 8, data bus.
- lcd_bl_n, out, 1, backlight cathode, constant 0.
- lcd_bl_p, out, 1, backlight anode, constant 1.

Behaviour:
- Reset values: lcd_en=0, lcd_rs=0, lcd_dat=0x00, upd_ready=0, busy=1, FSM=POR. Internal counters and latched data are cleared.
- Reset asserted mid-transfer aborts immediately, including while lcd_en is high. After release, the full POR + INIT sequence restarts.
- Transfer timing (one byte), all counts in clk cycles:
  - lcd_rs/lcd_dat are driven at phase start and held for SETUP_CYC + EN_CYC + gap.
  - lcd_en is high for exactly EN_CYC cycles, starting SETUP_CYC cycles after phase start.
  - gap = CLR_CYC if the byte is command 0x01, otherwise GAP_CYC.
- FSM states: POR -> INIT -> IDLE <-> WRITE.
  - POR: wait POR_CYC cycles.
  - INIT: command transfers 0x38, 0x0C, 0x06, 0x01 in that order, then go to IDLE.
  - IDLE: busy=0, upd_ready=1.
  - On upd_valid & upd_ready:
    - latch upd_data and upd_ok;
    - upd_ready drops the next cycle;
    - go to WRITE.
  - WRITE issues 17 transfers, then returns to IDLE:
    - command 0x80 | (LINE ? 0x40 : 0x00);
    - 16 data characters.
- Character layout (col 0..15):
  - col 0: 'C' (0x43) if ok, else 'E' (0x45);
  - col 1: space (0x20);
  - cols 2..(1+DATA_W/4): hex digits, MSB nibble first; 0-9 map to 0x30-0x39, A-F to 0x41-0x46 (uppercase);
  - remaining columns: space.
- upd_ready is 0 during POR/INIT/WRITE. upd_valid presented then is held off; no data is lost and no queue is kept.
- Latched data is stable for the whole WRITE; upd_data changing mid-write has no effect.
- The display is never blank-written before the first update; after INIT the LCD shows the cleared screen.
- busy = (state != IDLE).
- Minimum period between handshakes: 17 transfers, i.e. 17*(SETUP_CYC+EN_CYC+GAP_CYC) cycles plus 1.

Decomposition:
- Package lcd_pkg holds:
  - command constants: FUNC_8B_2L=0x38, DISP_ON=0x0C, ENTRY_INC=0x06, CLEAR=0x01, SET_DDRAM=0x80;
  - ASCII constants: 'C', 'E', space;
  - function nib2ascii(4b) -> 8b;
  - FSM state enum.
- Sub-module lcd_byte_writer: start/rs/byte in, done out. It owns the SETUP/EN/gap counter and selects CLR_CYC for 0x01. The top FSM only sequences bytes.

Test Plan (bench parameters POR_CYC=20, SETUP_CYC=2, EN_CYC=3, GAP_CYC=5, CLR_CYC=30; LCD bus model captures byte and rs on each lcd_en falling edge):
- Reset release, no update: 20 cycles idle, then captured commands 0x38, 0x0C, 0x06, 0x01. Gap after 0x01 is 30 cycles; upd_ready rises only after it.
- Update upd_data=0xABCDEFAB, upd_ok=1: captured 0x80 (rs=0), then "C ABCDEFAB" followed by 6 spaces (rs=1). Each lcd_en pulse is exactly 3 cycles high; upd_ready returns high after the last gap.
- DATA_W=8, LINE=1, data 0x0F, ok=0: command 0xC0, then "E 0F" followed by 12 spaces.
- upd_valid held high and upd_data changed to 0x12345678 during WRITE: first display unaffected; second handshake occurs only after busy falls; second write shows "C 12345678".
- Assert rst_n low while lcd_en is high mid-WRITE: lcd_en/lcd_rs/lcd_dat go 0 asynchronously, busy=1; after release the sequence restarts with 0x38 following POR_CYC.
- Every transfer: lcd_rw=0, lcd_bl_n=0, lcd_bl_p=1 throughout; lcd_dat/lcd_rs never change while lcd_en=1 (assertion).

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : lcd_pkg
// Brief  : HD44780 command/ASCII constants, FSM states and hex-to-ASCII helper.
// Rev    : 1.0
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] FUNC_8B_2L = 8'h38;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY_INC  = 8'h06;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] SET_DDRAM  = 8'h80;

    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_SP   = 8'h20;

    typedef enum logic [1:0] {
        ST_POR   = 2'd0,
        ST_INIT  = 2'd1,
        ST_IDLE  = 2'd2,
        ST_WRITE = 2'd3
    } lcd_state_t;

    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_byte_writer.sv
`default_nettype none
// ============================================================================
// Module : lcd_byte_writer
// Brief  : One HD44780 bus transfer: setup, enable pulse, then settle gap.
// Rev    : 1.0
// ============================================================================
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 12,
    parameter int GAP_CYC   = 2000,
    parameter int CLR_CYC   = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] din,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_dat
);

    localparam int c_GAP_MAX = (CLR_CYC > GAP_CYC) ? CLR_CYC : GAP_CYC;
    localparam int c_CNT_W   = $clog2(SETUP_CYC + EN_CYC + c_GAP_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_EN_ON    = c_CNT_W'(SETUP_CYC);
    localparam logic [c_CNT_W-1:0] c_EN_OFF   = c_CNT_W'(SETUP_CYC + EN_CYC);
    localparam logic [c_CNT_W-1:0] c_LAST_GAP = c_CNT_W'(SETUP_CYC + EN_CYC + GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CLR = c_CNT_W'(SETUP_CYC + EN_CYC + CLR_CYC - 1);

    logic               r_active;
    logic               r_clr;
    logic               r_rs;
    logic               r_en;
    logic [7:0]         r_dat;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_last;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_last    = r_clr ? (r_cnt == c_LAST_CLR) : (r_cnt == c_LAST_GAP);
    assign done      = r_active && w_last;

    // A new start is only issued on the final gap cycle, so rs/dat never move while enable is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_clr    <= 1'b0;
            r_rs     <= 1'b0;
            r_en     <= 1'b0;
            r_dat    <= 8'h00;
            r_cnt    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_clr    <= !rs && (din == CLEAR);
            r_rs     <= rs;
            r_dat    <= din;
            r_cnt    <= '0;
            r_en     <= (SETUP_CYC == 0);
        end else if (r_active) begin
            r_cnt    <= w_cnt_nxt;
            r_en     <= (w_cnt_nxt >= c_EN_ON) && (w_cnt_nxt < c_EN_OFF);
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

    assign lcd_rs  = r_rs;
    assign lcd_en  = r_en;
    assign lcd_dat = r_dat;

endmodule
`default_nettype wire

// File: rtl/lcd_hex_display.sv
`default_nettype none
// ============================================================================
// Module : lcd_hex_display
// Brief  : 16x2 HD44780 driver showing a status letter and a hex word on one row.
// Rev    : 1.0
// ============================================================================
module lcd_hex_display
    import lcd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LINE      = 0,
    parameter int POR_CYC   = 750000,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 12,
    parameter int GAP_CYC   = 2000,
    parameter int CLR_CYC   = 82000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              upd_ok,
    output logic              busy,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en,
    output logic [7:0]        lcd_dat,
    output logic              lcd_bl_n,
    output logic              lcd_bl_p
);

    localparam int c_POR_W = $clog2(POR_CYC + 1);
    localparam logic [c_POR_W-1:0] c_POR_LAST = c_POR_W'(POR_CYC - 1);
    localparam int         c_NIBS      = DATA_W / 4;
    localparam logic [4:0] c_HEX_END   = 5'(2 + DATA_W / 4);
    localparam logic [7:0] c_DDRAM_CMD = SET_DDRAM | ((LINE != 0) ? 8'h40 : 8'h00);
    localparam logic [4:0] c_INIT_LEN  = 5'd4;
    localparam logic [4:0] c_WRITE_LEN = 5'd17;

    lcd_state_t          r_state;
    lcd_state_t          w_state_nxt;
    logic [c_POR_W-1:0]  r_por_cnt;
    logic [4:0]          r_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_ok;

    logic                w_start;
    logic                w_rs;
    logic [7:0]          w_byte;
    logic                w_accept;
    logic                w_done;
    logic [7:0]          w_init_byte;
    logic [4:0]          w_col;
    logic [4:0]          w_nib_sel;
    logic [3:0]          w_nib;
    logic [7:0]          w_char;

    always_comb begin
        case (r_idx[1:0])
            2'd1:    w_init_byte = DISP_ON;
            2'd2:    w_init_byte = ENTRY_INC;
            2'd3:    w_init_byte = CLEAR;
            default: w_init_byte = FUNC_8B_2L;
        endcase
    end

    // r_idx counts transfers already issued; in WRITE, index n carries column n-1.
    assign w_col     = r_idx - 5'd1;
    assign w_nib_sel = w_col - 5'd2;

    always_comb begin
        w_nib = 4'h0;
        for (int k = 0; k < c_NIBS; k++) begin
            if (w_nib_sel == 5'(k)) begin
                w_nib = r_data[DATA_W-1-4*k -: 4];
            end
        end
    end

    always_comb begin
        if (w_col == 5'd0) begin
            w_char = r_ok ? ASCII_C : ASCII_E;
        end else if ((w_col >= 5'd2) && (w_col < c_HEX_END)) begin
            w_char = nib2ascii(w_nib);
        end else begin
            w_char = ASCII_SP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_POR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The first byte of each sequence starts on the transition cycle, so the
    // handshake-to-handshake period is exactly 17 transfers plus one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_rs        = 1'b0;
        w_byte      = 8'h00;
        w_accept    = 1'b0;
        upd_ready   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_POR: begin
                if (r_por_cnt == c_POR_LAST) begin
                    w_start     = 1'b1;
                    w_byte      = FUNC_8B_2L;
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                if (w_done) begin
                    if (r_idx == c_INIT_LEN) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_start = 1'b1;
                        w_byte  = w_init_byte;
                    end
                end
            end
            ST_IDLE: begin
                upd_ready = 1'b1;
                busy      = 1'b0;
                if (upd_valid) begin
                    w_accept    = 1'b1;
                    w_start     = 1'b1;
                    w_byte      = c_DDRAM_CMD;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_done) begin
                    if (r_idx == c_WRITE_LEN) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_start = 1'b1;
                        w_rs    = 1'b1;
                        w_byte  = w_char;
                    end
                end
            end
            default: w_state_nxt = ST_POR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_por_cnt <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_ok      <= 1'b0;
        end else begin
            if (r_state == ST_POR) begin
                r_por_cnt <= r_por_cnt + 1'b1;
            end
            if (w_start) begin
                r_idx <= ((r_state == ST_POR) || (r_state == ST_IDLE)) ? 5'd1 : r_idx + 5'd1;
            end
            if (w_accept) begin
                r_data <= upd_data;
                r_ok   <= upd_ok;
            end
        end
    end

    lcd_byte_writer #(
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .GAP_CYC   (GAP_CYC),
        .CLR_CYC   (CLR_CYC)
    ) u_writer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .rs      (w_rs),
        .din     (w_byte),
        .done    (w_done),
        .lcd_rs  (lcd_rs),
        .lcd_en  (lcd_en),
        .lcd_dat (lcd_dat)
    );

    assign lcd_rw   = 1'b0;
    assign lcd_bl_n = 1'b0;
    assign lcd_bl_p = 1'b1;

endmodule
`default_nettype wire
